auv_wb_sram: RTL

AUV_WB_SRAM -- requirements
Module: auv_wb_sram

---
 rtl/auv_wb_sram.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/auv_wb_sram.sv
// auv_wb_sram: Wishbone B4 pipelined 16-bit SRAM with a 2-deep in-order request queue.
// Define AUV_WB_SRAM_RANGE_CHECK_EN to answer out-of-window accesses with wb_err_o.
module auv_wb_sram #(
  parameter int ADDR_WIDTH = 24,
  parameter int MEM_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [15:0]           wb_dat_i,
  output logic [15:0]           wb_dat_o,
  input  logic [1:0]            wb_sel_i,
  input  logic                  wb_we_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_cyc_i,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  wb_stall_o
);

  localparam int WORDS = 1 << MEM_WIDTH;
  localparam logic [2:0] WS = 3'(WAIT_STATES);

  typedef struct packed {
    logic [MEM_WIDTH-1:0] idx;
    logic [15:0]          dat;
    logic [1:0]           sel;
    logic                 we;
    logic                 err;
  } req_t;

  typedef enum logic [1:0] {
    Q_EMPTY,
    Q_ONE,
    Q_FULL
  } occ_e;

  occ_e       occ_q, occ_d;
  req_t       q0_q, q1_q, q0_d, q1_d;
  req_t       in_req, head;
  logic [2:0] wcnt_q, wcnt_d, head_cnt;
  logic       stall_q, ack_q, err_q;
  logic [15:0] dat_q;
  logic       accept, head_valid, complete;
  logic       range_err;
  logic       unused_adr;

  logic [15:0] mem [WORDS];

`ifdef AUV_WB_SRAM_RANGE_CHECK_EN
  assign range_err =
    wb_adr_i[ADDR_WIDTH-1:MEM_WIDTH+1] !=
    BASE_ADDR[ADDR_WIDTH-1:MEM_WIDTH+1];
`else
  assign range_err = 1'b0;
`endif

  assign unused_adr =
    ^{wb_adr_i[0], wb_adr_i[ADDR_WIDTH-1:MEM_WIDTH+1]};

  assign accept = wb_cyc_i & wb_stb_i & ~stall_q & ~rst;

  assign in_req = '{
    idx: wb_adr_i[MEM_WIDTH:1],
    dat: wb_dat_i,
    sel: wb_sel_i,
    we:  wb_we_i,
    err: range_err
  };

  // An empty queue lets a new request act as head in its accept cycle
  always_comb begin
    head       = q0_q;
    head_cnt   = wcnt_q;
    head_valid = 1'b0;
    unique case (occ_q)
      Q_EMPTY: begin
        head       = in_req;
        head_cnt   = WS;
        head_valid = accept;
      end
      Q_ONE, Q_FULL: head_valid = 1'b1;
      default: head_valid = 1'b0;
    endcase
    complete = head_valid & (head_cnt == 3'd0)
             & wb_cyc_i & ~rst;
  end

  always_comb begin
    occ_d  = occ_q;
    q0_d   = q0_q;
    q1_d   = q1_q;
    wcnt_d = wcnt_q;
    if (rst || !wb_cyc_i) begin
      occ_d  = Q_EMPTY;
      wcnt_d = '0;
    end else begin
      unique case (occ_q)
        Q_EMPTY: begin
          if (accept && !complete) begin
            occ_d  = Q_ONE;
            q0_d   = in_req;
            wcnt_d = WS - 3'd1;
          end
        end
        Q_ONE: begin
          if (complete) begin
            if (accept) begin
              q0_d   = in_req;
              wcnt_d = WS;
            end else begin
              occ_d  = Q_EMPTY;
              wcnt_d = '0;
            end
          end else begin
            wcnt_d = wcnt_q - 3'd1;
            if (accept) begin
              occ_d = Q_FULL;
              q1_d  = in_req;
            end
          end
        end
        Q_FULL: begin
          if (complete) begin
            occ_d  = Q_ONE;
            q0_d   = q1_q;
            wcnt_d = WS;
          end else begin
            wcnt_d = wcnt_q - 3'd1;
          end
        end
        default: begin
          occ_d  = Q_EMPTY;
          wcnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q   <= Q_EMPTY;
      wcnt_q  <= '0;
      stall_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      occ_q   <= occ_d;
      wcnt_q  <= wcnt_d;
      stall_q <= (occ_d == Q_FULL);
      ack_q   <= complete & ~head.err;
      err_q   <= complete & head.err;
      dat_q   <= (complete && !head.we && !head.err)
               ? mem[head.idx] : '0;
    end
  end

  always_ff @(posedge clk) begin
    q0_q <= q0_d;
    q1_q <= q1_d;
  end

  // Storage is never reset; only completed in-range writes touch it
  always_ff @(posedge clk) begin
    if (complete && head.we && !head.err) begin
      if (head.sel[0]) mem[head.idx][7:0]  <= head.dat[7:0];
      if (head.sel[1]) mem[head.idx][15:8] <= head.dat[15:8];
    end
  end

  assign wb_dat_o   = dat_q;
  assign wb_ack_o   = ack_q;
  assign wb_err_o   = err_q;
  assign wb_stall_o = stall_q;

endmodule
